// File: rtl/tlc_pkg.sv
// Shared types and helpers for the N-approach traffic-light controller.
// State encodings and the round-robin next-requester search.
package tlc_pkg;

    typedef enum logic [1:0] {
        GREEN_MIN = 2'd0,
        GREEN_EXT = 2'd1,
        YELLOW    = 2'd2,
        ALL_RED   = 2'd3
    } tlc_state_e;

    // First requester after active_dir (wrapping), never active_dir itself; supports up to 32 approaches.
    function automatic logic [4:0] rr_next(input logic [31:0] sensor,
                                           input logic [4:0]  active_dir,
                                           input logic [5:0]  num_dir);
        logic [4:0] sel;
        logic       found;
        logic [5:0] idx;
        sel   = active_dir;
        found = 1'b0;
        for (int k = 1; k < 32; k++) begin
            idx = {1'b0, active_dir} + 6'(k);
            if (idx >= num_dir) begin
                idx = idx - num_dir;
            end else begin
                idx = idx;
            end
            if (!found && (6'(k) < num_dir) && sensor[idx[4:0]]) begin
                sel   = idx[4:0];
                found = 1'b1;
            end else begin
                sel   = sel;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/tlc_phase_timer.sv
// Phase timer: counts tick_en strobes up to a per-phase terminal value.
// done fires on the strobe that hits the terminal value; hold freezes the count.
module tlc_phase_timer #(
    parameter int CNT_W = 13
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick_en,
    input  logic             hold,
    input  logic             clear,
    input  logic [CNT_W-1:0] term,
    output logic             done
);

    logic [CNT_W-1:0] cnt_r;

    assign done = tick_en && !hold && (cnt_r == term);

    // Counter: a state change or terminal hit restarts the phase at zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (clear || done) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (tick_en && !hold) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/tlc_multi_fsm.sv
// N-approach traffic-light controller: round-robin service, capped green extension, all-red clearance.
// Optional build macro TLC_PREEMPT_EN adds preempt_req/preempt_dir emergency preemption.
module tlc_multi_fsm
    import tlc_pkg::*;
#(
    parameter int NUM_DIR     = 4,
    parameter int CNT_W       = 13,
    parameter int T_MIN_GREEN = 4999,
    parameter int T_EXT       = 999,
    parameter int T_YELLOW    = 999,
    parameter int T_ALL_RED   = 199,
    parameter int MAX_EXT     = 4,
    localparam int DIR_W      = $clog2(NUM_DIR)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tick_en,
    input  logic [NUM_DIR-1:0] sensor,
`ifdef TLC_PREEMPT_EN
    input  logic               preempt_req,
    input  logic [DIR_W-1:0]   preempt_dir,
`endif
    output logic [NUM_DIR-1:0] green,
    output logic [NUM_DIR-1:0] yellow,
    output logic [NUM_DIR-1:0] red,
    output logic [DIR_W-1:0]   active_dir,
    output logic               phase_done
);

    localparam int EXT_W = $clog2(MAX_EXT + 1);
    localparam logic [EXT_W-1:0] EXT_LAST = EXT_W'(MAX_EXT - 1);

    tlc_state_e         state_r, state_nxt;
    logic [EXT_W-1:0]   ext_cnt_r, ext_nxt;
    logic [DIR_W-1:0]   active_dir_r, act_nxt;
    logic [DIR_W-1:0]   next_dir_r, nd_nxt;
    logic [DIR_W-1:0]   rr_dir_s;
    logic [NUM_DIR-1:0] onehot_act_s, onehot_nxt_s;
    logic [NUM_DIR-1:0] green_nxt, yellow_nxt, red_nxt;
    logic [CNT_W-1:0]   term_s;
    logic               done_s, hold_s, other_s, own_s;

    assign onehot_act_s = NUM_DIR'(1) << active_dir_r;
    assign other_s      = |(sensor & ~onehot_act_s);
    assign own_s        = sensor[active_dir_r];
    assign rr_dir_s     = DIR_W'(rr_next(32'(sensor), 5'(active_dir_r), 6'(NUM_DIR)));
    assign active_dir   = active_dir_r;
    assign phase_done   = (state_nxt != state_r);

`ifdef TLC_PREEMPT_EN
    assign hold_s = preempt_req && (state_r == GREEN_EXT) && (preempt_dir == active_dir_r);
`else
    assign hold_s = 1'b0;
`endif

    // Terminal count for the phase currently running.
    always_comb begin
        term_s = CNT_W'(T_MIN_GREEN);
        case (state_r)
            GREEN_MIN: term_s = CNT_W'(T_MIN_GREEN);
            GREEN_EXT: term_s = CNT_W'(T_EXT);
            YELLOW:    term_s = CNT_W'(T_YELLOW);
            ALL_RED:   term_s = CNT_W'(T_ALL_RED);
            default:   term_s = CNT_W'(T_MIN_GREEN);
        endcase
    end

    tlc_phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .tick_en (tick_en),
        .hold    (hold_s),
        .clear   (phase_done),
        .term    (term_s),
        .done    (done_s)
    );

    // Next-state logic: phase sequencing, extension cap and next-direction latch.
    always_comb begin
        state_nxt = state_r;
        ext_nxt   = ext_cnt_r;
        act_nxt   = active_dir_r;
        nd_nxt    = next_dir_r;
        case (state_r)
            GREEN_MIN: begin
                if (done_s) begin
                    state_nxt = GREEN_EXT;
                    ext_nxt   = EXT_W'(0);
                end else begin
                    state_nxt = GREEN_MIN;
                end
            end
            GREEN_EXT: begin
                // Without competing demand the green rests here indefinitely.
                if (done_s && other_s && (!own_s || (ext_cnt_r == EXT_LAST))) begin
                    state_nxt = YELLOW;
                    nd_nxt    = rr_dir_s;
                end else if (done_s && (ext_cnt_r != EXT_LAST)) begin
                    ext_nxt = ext_cnt_r + EXT_W'(1);
                end else begin
                    ext_nxt = ext_cnt_r;
                end
            end
            YELLOW: begin
                if (done_s) begin
                    state_nxt = ALL_RED;
                end else begin
                    state_nxt = YELLOW;
                end
            end
            ALL_RED: begin
                if (done_s) begin
                    state_nxt = GREEN_MIN;
                    act_nxt   = next_dir_r;
                end else begin
                    state_nxt = ALL_RED;
                end
            end
            default: state_nxt = GREEN_MIN;
        endcase
`ifdef TLC_PREEMPT_EN
        if (preempt_req) begin
            if ((state_r == GREEN_MIN) || (state_r == GREEN_EXT)) begin
                if (preempt_dir != active_dir_r) begin
                    state_nxt = YELLOW;
                    nd_nxt    = preempt_dir;
                end else begin
                    state_nxt = GREEN_EXT;
                    ext_nxt   = (state_r == GREEN_MIN) ? EXT_W'(0) : ext_cnt_r;
                end
            end else begin
                nd_nxt = preempt_dir;
                if (state_nxt == GREEN_MIN) begin
                    act_nxt = preempt_dir;
                end else begin
                    act_nxt = active_dir_r;
                end
            end
        end else begin
            nd_nxt = nd_nxt;
        end
`endif
    end

    // Lamp decode from the next state so the lamp registers line up with the state register.
    always_comb begin
        onehot_nxt_s = NUM_DIR'(1) << act_nxt;
        green_nxt    = {NUM_DIR{1'b0}};
        yellow_nxt   = {NUM_DIR{1'b0}};
        red_nxt      = {NUM_DIR{1'b1}};
        case (state_nxt)
            GREEN_MIN, GREEN_EXT: begin
                green_nxt = onehot_nxt_s;
                red_nxt   = ~onehot_nxt_s;
            end
            YELLOW: begin
                yellow_nxt = onehot_nxt_s;
                red_nxt    = ~onehot_nxt_s;
            end
            ALL_RED: red_nxt = {NUM_DIR{1'b1}};
            default: red_nxt = {NUM_DIR{1'b1}};
        endcase
    end

    // State, bookkeeping and lamp registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= GREEN_MIN;
            ext_cnt_r    <= EXT_W'(0);
            active_dir_r <= DIR_W'(0);
            next_dir_r   <= DIR_W'(0);
            green        <= NUM_DIR'(1);
            yellow       <= {NUM_DIR{1'b0}};
            red          <= ~NUM_DIR'(1);
        end else begin
            state_r      <= state_nxt;
            ext_cnt_r    <= ext_nxt;
            active_dir_r <= act_nxt;
            next_dir_r   <= nd_nxt;
            green        <= green_nxt;
            yellow       <= yellow_nxt;
            red          <= red_nxt;
        end
    end

endmodule

// File: tb/tb_tlc_multi_fsm.sv
// Directed bench for tlc_multi_fsm with short phase times (4 approaches).
// Preemption steps are compiled in when TLC_PREEMPT_EN is defined.
module tb_tlc_multi_fsm;

    logic       clk;
    logic       reset;
    logic       tick_en;
    logic [3:0] sensor;
    logic [3:0] green, yellow, red;
    logic [1:0] active_dir;
    logic       phase_done;
`ifdef TLC_PREEMPT_EN
    logic       preempt_req;
    logic [1:0] preempt_dir;
`endif

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int bad;
    int pulses;

    tlc_multi_fsm #(
        .NUM_DIR     (4),
        .CNT_W       (13),
        .T_MIN_GREEN (3),
        .T_EXT       (1),
        .T_YELLOW    (1),
        .T_ALL_RED   (0),
        .MAX_EXT     (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .tick_en    (tick_en),
        .sensor     (sensor),
`ifdef TLC_PREEMPT_EN
        .preempt_req(preempt_req),
        .preempt_dir(preempt_dir),
`endif
        .green      (green),
        .yellow     (yellow),
        .red        (red),
        .active_dir (active_dir),
        .phase_done (phase_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] lv(input logic [3:0] g, input logic [3:0] y,
                                       input logic [3:0] r, input logic [1:0] a);
        return {18'd0, g, y, r, a};
    endfunction

    function automatic logic [31:0] lamps();
        return lv(green, yellow, red, active_dir);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset(input logic [3:0] s);
        reset   = 1'b1;
        tick_en = 1'b1;
        sensor  = s;
        step();
        reset = 1'b0;
        cyc   = 0;
    endtask

    initial begin
        reset   = 1'b1;
        tick_en = 1'b1;
        sensor  = 4'b0000;
`ifdef TLC_PREEMPT_EN
        preempt_req = 1'b0;
        preempt_dir = 2'd0;
`endif

        // Idle: dir 0 rests in green, one phase_done pulse (GREEN_MIN -> GREEN_EXT).
        do_reset(4'b0000);
        bad    = 0;
        pulses = 0;
        for (int c = 0; c < 100; c++) begin
            if (c == 0) chk("s1_reset_lamps", lamps(), lv(4'b0001, 4'b0000, 4'b1110, 2'd0));
            if (c == 3) chk("s1_done_gmin_exit", 32'(phase_done), 32'd1);
            if (lamps() != lv(4'b0001, 4'b0000, 4'b1110, 2'd0)) bad++;
            if (phase_done) pulses++;
            step();
        end
        chk("s1_lamps_stable", 32'(bad), 32'd0);
        chk("s1_pulse_count", 32'(pulses), 32'd1);
        chk("s1_rest_state", 32'(dut.state_r), 32'd1);

        // Single request on dir 2, then round robin over 3,0,1 with dir 2 dropping out.
        do_reset(4'b0100);
        for (int c = 0; c < 10; c++) begin
            if (c <= 5)      chk($sformatf("s2_lamps_c%0d", c), lamps(), lv(4'b0001, 4'b0000, 4'b1110, 2'd0));
            else if (c <= 7) chk($sformatf("s2_lamps_c%0d", c), lamps(), lv(4'b0000, 4'b0001, 4'b1110, 2'd0));
            else if (c == 8) chk($sformatf("s2_lamps_c%0d", c), lamps(), lv(4'b0000, 4'b0000, 4'b1111, 2'd0));
            else             chk($sformatf("s2_lamps_c%0d", c), lamps(), lv(4'b0100, 4'b0000, 4'b1011, 2'd2));
            if (c == 4) chk("s2_no_done_c4", 32'(phase_done), 32'd0);
            if (c == 5) chk("s2_done_to_yellow", 32'(phase_done), 32'd1);
            step();
        end
        sensor = 4'b1011;
        bad    = 0;
        for (int c = 10; c < 52; c++) begin
            if (c >= 15 && green[2]) bad++;
            if (c == 18) chk("s3_green_dir3", lamps(), lv(4'b1000, 4'b0000, 4'b0111, 2'd3));
            if (c == 29) chk("s3_green_dir0", lamps(), lv(4'b0001, 4'b0000, 4'b1110, 2'd0));
            if (c == 40) chk("s3_green_dir1", lamps(), lv(4'b0010, 4'b0000, 4'b1101, 2'd1));
            if (c == 51) chk("s3_green_dir3_again", lamps(), lv(4'b1000, 4'b0000, 4'b0111, 2'd3));
            step();
        end
        chk("s3_dir2_skipped", 32'(bad), 32'd0);

        // Own and competing demand: extension capped at MAX_EXT slices.
        do_reset(4'b0011);
        for (int c = 0; c < 12; c++) begin
            if (c == 5)  chk("s4_ext_rest_no_done", 32'(phase_done), 32'd0);
            if (c == 7)  chk("s4_ext_last", lamps(), lv(4'b0001, 4'b0000, 4'b1110, 2'd0));
            if (c == 7)  chk("s4_done_ext_cap", 32'(phase_done), 32'd1);
            if (c == 8)  chk("s4_yellow", lamps(), lv(4'b0000, 4'b0001, 4'b1110, 2'd0));
            if (c == 10) chk("s4_all_red", lamps(), lv(4'b0000, 4'b0000, 4'b1111, 2'd0));
            if (c == 11) chk("s4_green_dir1", lamps(), lv(4'b0010, 4'b0000, 4'b1101, 2'd1));
            step();
        end

        // Slow timebase: strobe every 4th cycle stretches every phase by 4.
        do_reset(4'b0100);
        for (int c = 0; c < 37; c++) begin
            tick_en = (c % 4 == 3);
            #1;
            if (c == 22) chk("s5_hold_no_tick", 32'(phase_done), 32'd0);
            if (c == 23) chk("s5_ext_end", lamps(), lv(4'b0001, 4'b0000, 4'b1110, 2'd0));
            if (c == 23) chk("s5_done_on_strobe", 32'(phase_done), 32'd1);
            if (c == 24) chk("s5_yellow", lamps(), lv(4'b0000, 4'b0001, 4'b1110, 2'd0));
            if (c == 35) chk("s5_all_red", lamps(), lv(4'b0000, 4'b0000, 4'b1111, 2'd0));
            if (c == 36) chk("s5_green_dir2", lamps(), lv(4'b0100, 4'b0000, 4'b1011, 2'd2));
            step();
        end

        // Reset in the middle of YELLOW returns to dir 0 GREEN_MIN with a fresh timer.
        do_reset(4'b0100);
        repeat (6) step();
        chk("s5r_in_yellow", lamps(), lv(4'b0000, 4'b0001, 4'b1110, 2'd0));
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("s5r_lamps", lamps(), lv(4'b0001, 4'b0000, 4'b1110, 2'd0));
        chk("s5r_state", 32'(dut.state_r), 32'd0);
        chk("s5r_cnt", 32'(dut.u_timer.cnt_r), 32'd0);
        repeat (3) step();
        chk("s5r_full_min_green", 32'(phase_done), 32'd1);

`ifdef TLC_PREEMPT_EN
        // Preempt to dir 3 from GREEN_MIN, then freeze dir 3 green against demand.
        do_reset(4'b0000);
        step();
        preempt_req = 1'b1;
        preempt_dir = 2'd3;
        #1;
        chk("p_done_on_preempt", 32'(phase_done), 32'd1);
        step();
        preempt_req = 1'b0;
        chk("p_yellow", lamps(), lv(4'b0000, 4'b0001, 4'b1110, 2'd0));
        repeat (2) step();
        chk("p_all_red", lamps(), lv(4'b0000, 4'b0000, 4'b1111, 2'd0));
        step();
        chk("p_green_dir3", lamps(), lv(4'b1000, 4'b0000, 4'b0111, 2'd3));
        sensor      = 4'b0001;
        preempt_req = 1'b1;
        preempt_dir = 2'd3;
        repeat (20) step();
        chk("p_frozen_green", lamps(), lv(4'b1000, 4'b0000, 4'b0111, 2'd3));
        chk("p_frozen_state", 32'(dut.state_r), 32'd1);
        preempt_req = 1'b0;
        sensor      = 4'b0000;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
